pipe_hazard_unit: RTL

Hazard, forwarding and flush controller for the 5-stage LEGv8 pipeline (IF/ID/EX/MEM/WB). It keeps a scoreboard of the destination-register records for the instructions in EX and MEM. From that it produces:
- the load-use or RAW stall,
- per-operand forwarding selects, registered so they are valid during the consumer's EX cycle,
- the three pipeline-register flushes for a branch taken in MEM.
It adds a no-forwarding mode and saturating stall/flush performance counters. The existing pipeline has no hazard handling.

---
 rtl/pipe_hazard_unit_pkg.sv | 30 +++
 rtl/pipe_hazard_unit_sat_counter.sv | 23 ++
 rtl/pipe_hazard_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types for the pipeline hazard/forwarding controller:
// forwarding-select encodings, scoreboard entry record and match helper.
package pipe_hazard_unit_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_EXMEM   = 2'd1;
    localparam logic [1:0] FWD_MEMWB   = 2'd2;

    localparam int SB_RD_W = 5;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               reg_write;
        logic               mem_read;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // True when the entry produces the register that a live source reads.
    function automatic logic sb_match(
        input sb_entry_t          e,
        input logic [SB_RD_W-1:0] src,
        input logic               used,
        input logic [SB_RD_W-1:0] zero
    );
        return e.valid & e.reg_write & (e.rd == src) & (src != zero) & used;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Ports: clk, reset (async high), inc, clr, count[W-1:0].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and branch-flush controller for a 5-stage pipeline.
// Ports: ID-stage instruction record and MEM branch-taken in; stall,
// three flushes, registered forwarding selects and perf counters out.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31,
    parameter bit FWD_EN   = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rn,
    input  logic              id_rn_used,
    input  logic [REG_AW-1:0] id_rm,
    input  logic              id_rm_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              br_taken_mem,
    input  logic              clr_cnt,
    output logic              stall,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    sb_entry_t          ex_q, mem_q, id_rec;
    logic [SB_RD_W-1:0] rn, rm, rd, zr;
    logic               ex_rn, ex_rm, mem_rn, mem_rm;
    logic               raw, load;
    logic [1:0]         nxt_a, nxt_b;

    assign rn = SB_RD_W'(id_rn);
    assign rm = SB_RD_W'(id_rm);
    assign rd = SB_RD_W'(id_rd);
    assign zr = SB_RD_W'(ZERO_REG);

    assign id_rec = '{valid: 1'b1, rd: rd,
                      reg_write: id_reg_write,
                      mem_read: id_mem_read};

    assign ex_rn  = sb_match(ex_q,  rn, id_rn_used, zr);
    assign ex_rm  = sb_match(ex_q,  rm, id_rm_used, zr);
    assign mem_rn = sb_match(mem_q, rn, id_rn_used, zr);
    assign mem_rm = sb_match(mem_q, rm, id_rm_used, zr);

    // With forwarding only a load in EX cannot be bypassed in time;
    // without it every in-flight producer must drain first.
    always_comb begin
        if (FWD_EN) begin
            raw = ex_q.mem_read & (ex_rn | ex_rm);
        end else begin
            raw = ex_rn | ex_rm | mem_rn | mem_rm;
        end
    end

    // The branch flush kills the stalled instruction anyway.
    assign stall        = raw & ~br_taken_mem;
    assign flush_if_id  = br_taken_mem;
    assign flush_id_ex  = br_taken_mem;
    assign flush_ex_mem = br_taken_mem;

    assign load = id_valid & ~stall & ~br_taken_mem;

    // The nearer producer (EX) holds the newer value of the register.
    always_comb begin
        nxt_a = FWD_REGFILE;
        nxt_b = FWD_REGFILE;
        if (FWD_EN && load) begin
            if (ex_rn)       nxt_a = FWD_EXMEM;
            else if (mem_rn) nxt_a = FWD_MEMWB;
            if (ex_rm)       nxt_b = FWD_EXMEM;
            else if (mem_rm) nxt_b = FWD_MEMWB;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= SB_EMPTY;
            mem_q <= SB_EMPTY;
            fwd_a <= FWD_REGFILE;
            fwd_b <= FWD_REGFILE;
        end else begin
            mem_q <= br_taken_mem ? SB_EMPTY : ex_q;
            ex_q  <= load ? id_rec : SB_EMPTY;
            fwd_a <= nxt_a;
            fwd_b <= nxt_b;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .clr   (clr_cnt),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (br_taken_mem),
        .clr   (clr_cnt),
        .count (flush_cnt)
    );

endmodule
